// File: rtl/gcd_requester.sv
// GCD requester: accepts operand pairs, drives an external GCD core
// through clear/load/run, and returns the result or a timeout abort.
module gcd_requester #(
  parameter int TIMEOUT = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_a,
  input  logic [4:0] req_b,
  output logic       core_reset,
  output logic       core_load,
  output logic [4:0] core_a,
  output logic [4:0] core_b,
  input  logic [4:0] core_result,
  input  logic       core_done,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [4:0] rsp_gcd,
  output logic       rsp_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_RUN,
    S_SETTLE,
    S_RESP
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_cnt;
  logic [4:0] r_a;
  logic [4:0] r_b;
  logic [4:0] r_gcd;
  logic       r_tmo;
  logic       r_core_reset;
  logic       r_core_load;
  logic       r_req_ready;
  logic       r_rsp_valid;
  logic       w_accept;
  logic       w_zero;
  logic       w_expire;

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_zero   = (req_a == 5'd0) || (req_b == 5'd0);
  assign w_expire = !core_done && (r_cnt == LP_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; done wins over timeout in RUN
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) w_next = w_zero ? S_RESP : S_CLR;
      end
      S_CLR:    w_next = S_LOAD;
      S_LOAD:   w_next = S_RUN;
      S_RUN: begin
        if (core_done)     w_next = S_SETTLE;
        else if (w_expire) w_next = S_RESP;
      end
      S_SETTLE: w_next = S_RESP;
      S_RESP: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Registered handshake and core strobes, decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_core_reset <= 1'b0;
      r_core_load  <= 1'b1;
    end else begin
      r_req_ready  <= (w_next == S_IDLE);
      r_rsp_valid  <= (w_next == S_RESP);
      r_core_reset <= (w_next != S_CLR);
      r_core_load  <= (w_next != S_LOAD);
    end
  end

  // Operand register, RUN cycle counter and response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_gcd <= '0;
      r_tmo <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a <= req_a;
        r_b <= req_b;
        if (w_zero) begin
          r_gcd <= req_a | req_b;
          r_tmo <= 1'b0;
        end
      end
      if (r_state == S_LOAD) r_cnt <= '0;
      if (r_state == S_RUN && !core_done) begin
        r_cnt <= r_cnt + 8'd1;
        if (w_expire) begin
          r_gcd <= '0;
          r_tmo <= 1'b1;
        end
      end
      if (r_state == S_SETTLE) begin
        r_gcd <= core_result;
        r_tmo <= 1'b0;
      end
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign core_reset  = r_core_reset;
  assign core_load   = r_core_load;
  assign core_a      = r_a;
  assign core_b      = r_b;
  assign rsp_gcd     = r_gcd;
  assign rsp_timeout = r_tmo;

endmodule

// File: tb/tb_gcd_requester.sv
// Bench for gcd_requester: behavioural GCD core with programmable
// done delay, directed corner cases and random operand pairs.
module tb_gcd_requester;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_a;
  logic [4:0] req_b;
  logic       core_reset;
  logic       core_load;
  logic [4:0] core_a;
  logic [4:0] core_b;
  logic [4:0] core_result;
  logic       core_done;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_gcd;
  logic       rsp_timeout;

  int n_pass = 0;
  int n_chk  = 0;

  int unsigned core_dly = 0;
  logic        kill_done = 1'b0;

  logic [4:0]  m_a, m_b;
  logic [4:0]  m_res = '0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int unsigned m_cnt = 0;

  int n_clr = 0;
  int n_load = 0;
  int n_hs = 0;

  gcd_requester #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .core_reset  (core_reset),
    .core_load   (core_load),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_result (core_result),
    .core_done   (core_done),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_gcd     (rsp_gcd),
    .rsp_timeout (rsp_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] gcd_ref(input logic [4:0] a,
                                         input logic [4:0] b);
    int x, y, t;
    x = int'(a);
    y = int'(b);
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return 5'(x);
  endfunction

  // Core model: done core_dly+1 cycles after load, result one cycle later
  always @(posedge clk) begin
    if (!core_reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= '0;
    end else if (!core_load) begin
      m_busy <= 1'b1;
      m_done <= 1'b0;
      m_cnt  <= core_dly;
      m_a    <= core_a;
      m_b    <= core_b;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        m_done <= 1'b1;
        m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (m_done) begin
      m_done <= 1'b0;
      m_res  <= gcd_ref(m_a, m_b);
    end
  end

  assign core_done   = m_done & ~kill_done;
  assign core_result = m_res;

  // Pulse and handshake counters
  always @(posedge clk) begin
    if (!reset && core_reset === 1'b0) n_clr  <= n_clr + 1;
    if (!reset && core_load === 1'b0)  n_load <= n_load + 1;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) n_hs <= n_hs + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [4:0] a, input logic [4:0] b,
                        input int unsigned d, input int bp);
    logic        byp, tmo;
    logic [4:0]  eg, held;
    int          elat, lat, c0, l0, h0;
    byp  = (a == 0) || (b == 0);
    tmo  = !byp && (kill_done || (d + 2 > 8));
    eg   = byp ? (a | b) : (tmo ? 5'd0 : gcd_ref(a, b));
    elat = byp ? 1 : (tmo ? 11 : 3 + (int'(d) + 2) + 1);
    core_dly = d;
    c0 = n_clr;
    l0 = n_load;
    h0 = n_hs;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_a = $urandom_range(0, 31);
    req_b = $urandom_range(0, 31);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      if (core_load === 1'b0) begin
        check("load_a", 32'(core_a), 32'(a));
        check("load_b", 32'(core_b), 32'(b));
      end
      tick();
      lat++;
    end
    check("latency", lat, elat);
    check("rsp_gcd", 32'(rsp_gcd), 32'(eg));
    check("rsp_tmo", 32'(rsp_timeout), 32'(tmo));
    check("rdy_resp", 32'(req_ready), 0);
    check("clr_cnt", n_clr - c0, byp ? 0 : 1);
    check("load_cnt", n_load - l0, byp ? 0 : 1);
    held = rsp_gcd;
    for (int i = 0; i < bp; i++) begin
      tick();
      check("bp_gcd", 32'(rsp_gcd), 32'(held));
      check("bp_rdy", 32'(req_ready), 0);
      check("bp_vld", 32'(rsp_valid), 1);
    end
    req_a = 5'd5;
    req_b = 5'd0;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("rel_vld", 32'(rsp_valid), 0);
    check("rel_rdy", 32'(req_ready), 1);
    check("rel_opa", 32'(core_a), 32'(a));
    check("hs_once", n_hs - h0, 1);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    check("rst_rdy", 32'(req_ready), 1);
    check("rst_vld", 32'(rsp_valid), 0);
    check("rst_gcd", 32'(rsp_gcd), 0);
    check("rst_tmo", 32'(rsp_timeout), 0);
    check("rst_creset", 32'(core_reset), 0);
    check("rst_cload", 32'(core_load), 1);
    check("rst_ca", 32'(core_a), 0);
    check("rst_cb", 32'(core_b), 0);
    reset = 1'b0;
    tick();
    check("post_creset", 32'(core_reset), 1);
    check("post_rdy", 32'(req_ready), 1);

    do_req(5'd30, 5'd10, 2, 0);
    do_req(5'd15, 5'd25, 1, 0);
    do_req(5'd21, 5'd14, 3, 0);
    do_req(5'd17, 5'd31, 0, 0);
    do_req(5'd0, 5'd10, 0, 0);
    do_req(5'd0, 5'd0, 0, 0);
    do_req(5'd30, 5'd10, 4, 5);

    kill_done = 1'b1;
    do_req(5'd30, 5'd10, 0, 1);
    kill_done = 1'b0;
    do_req(5'd12, 5'd18, 6, 0);
    do_req(5'd12, 5'd18, 7, 0);

    core_dly = 3;
    req_a = 5'd30;
    req_b = 5'd10;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check("mr_vld", 32'(rsp_valid), 0);
    check("mr_creset", 32'(core_reset), 0);
    check("mr_rdy", 32'(req_ready), 1);
    reset = 1'b0;
    tick();
    check("mr_post_creset", 32'(core_reset), 1);
    check("mr_post_vld", 32'(rsp_valid), 0);
    do_req(5'd15, 5'd25, 2, 0);

    for (int k = 0; k < 12; k++) begin
      logic [4:0] ra, rb;
      ra = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rb = 5'($urandom_range(0, 31));
      do_req(ra, rb, $urandom_range(0, 5), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
